usb_rx_bit_decoder: RTL and testbench

//   Consumes the two synchronized USB line signals (D+ / D-) from the receive

---
 rtl/usb_rx_bit_decoder.sv | 129 ++++++++++++
 tb/tb_usb_rx_bit_decoder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/usb_rx_bit_decoder.sv
// usb_rx_bit_decoder: full-speed USB receive bit recovery, NRZI decode, unstuffing, EOP/error detection
//
// Ports:
//   clk          in  system clock (CLKS_PER_BIT clocks per USB bit), rising edge
//   rst          in  asynchronous active-high reset
//   d_plus_sync  in  synchronized D+ (J = D+ 1 / D- 0)
//   d_minus_sync in  synchronized D-
//   bit_out      out decoded data bit, meaningful only with bit_valid
//   bit_valid    out 1-cycle strobe per non-stuffed decoded bit
//   eop          out 1-cycle strobe on a clean end of packet (SE0 then J)
//   rx_error     out 1-cycle strobe on a bit-stuff violation or bad EOP
//   receiving    out high while a packet is in progress
module usb_rx_bit_decoder #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_PT    = 3,
    parameter int STUFF_LEN    = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic d_plus_sync,
    input  logic d_minus_sync,
    output logic bit_out,
    output logic bit_valid,
    output logic eop,
    output logic rx_error,
    output logic receiving
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int OW = $clog2(STUFF_LEN + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_EOP} state_t;

    state_t        state_q;
    logic [TW-1:0] timer_q, timer_d;
    logic [OW-1:0] ones_q;
    logic [1:0]    se0_cnt_q;
    logic          d_plus_q, prev_dp_q;
    logic          active, line_edge, start, sample_now, se0, line_j, dec;

    assign active     = state_q != ST_IDLE;
    assign line_edge  = d_plus_q ^ d_plus_sync;
    // Packet start is the J->K transition out of idle: D+ falls while D- is high.
    assign start      = !active && d_plus_q && !d_plus_sync && d_minus_sync;
    assign se0        = !d_plus_sync && !d_minus_sync;
    assign line_j     = d_plus_sync && !d_minus_sync;
    // NRZI: no change on the line is a 1, a change is a 0.
    assign dec        = d_plus_sync == prev_dp_q;
    // An edge landing on the sample point resynchronises instead of sampling.
    assign sample_now = active && !line_edge && timer_q == TW'(SAMPLE_PT);

    // The edge cycle counts as timer 0, so the register is loaded with 1.
    always_comb begin
        timer_d = (start || (active && line_edge)) ? TW'(1) :
                  !active                          ? '0 :
                  timer_q == TW'(CLKS_PER_BIT - 1) ? '0 : timer_q + TW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            ones_q    <= '0;
            se0_cnt_q <= '0;
            d_plus_q  <= 1'b1;
            prev_dp_q <= 1'b1;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            eop       <= 1'b0;
            rx_error  <= 1'b0;
            receiving <= 1'b0;
        end else begin
            d_plus_q  <= d_plus_sync;
            timer_q   <= timer_d;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            eop       <= 1'b0;
            rx_error  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_RECV;
                        prev_dp_q <= 1'b1;
                        ones_q    <= '0;
                        receiving <= 1'b1;
                    end
                end
                ST_RECV: begin
                    if (sample_now) begin
                        if (se0) begin
                            state_q   <= ST_EOP;
                            se0_cnt_q <= 2'd1;
                        end else begin
                            prev_dp_q <= d_plus_sync;
                            if (ones_q == OW'(STUFF_LEN)) begin
                                // After a full run of 1s the next bit must be a stuffed 0.
                                ones_q <= '0;
                                if (dec) begin
                                    rx_error  <= 1'b1;
                                    state_q   <= ST_IDLE;
                                    receiving <= 1'b0;
                                end
                            end else begin
                                bit_valid <= 1'b1;
                                bit_out   <= dec;
                                ones_q    <= dec ? ones_q + OW'(1) : '0;
                            end
                        end
                    end
                end
                ST_EOP: begin
                    if (sample_now) begin
                        if (se0) begin
                            se0_cnt_q <= se0_cnt_q == 2'd3 ? 2'd3 : se0_cnt_q + 2'd1;
                        end else begin
                            state_q   <= ST_IDLE;
                            receiving <= 1'b0;
                            eop       <= line_j;
                            rx_error  <= !line_j;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    receiving <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// tb_usb_rx_bit_decoder: scoreboard bench with directed line symbols and hand-computed strobes
module tb_usb_rx_bit_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dp = 1'b1;
    logic dm = 1'b0;
    logic bit_out, bit_valid, eop, rx_error, receiving;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    localparam int SJ = 0, SK = 1, SE0 = 2;
    localparam int NONE = 0, BIT = 1, EOPK = 2, ERR = 3;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } exp_t;
    exp_t exp_q[$];

    usb_rx_bit_decoder dut (
        .clk(clk),
        .rst(rst),
        .d_plus_sync(dp),
        .d_minus_sync(dm),
        .bit_out(bit_out),
        .bit_valid(bit_valid),
        .eop(eop),
        .rx_error(rx_error),
        .receiving(receiving)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive a line symbol for n clocks starting at a negedge; the strobe is
    // expected off clocks after the first posedge that sees the symbol.
    task automatic sym(input int s, input int n, input int kind, input int val, input int off);
        dp = s == SJ;
        dm = s == SK;
        if (kind != NONE) exp_q.push_back('{kind, val, cyc + 1 + off});
        repeat (n) @(negedge clk);
    endtask

    task automatic sync_pat();
        for (int i = 0; i < 7; i++) sym(i % 2 == 0 ? SK : SJ, 8, BIT, 0, 3);
        sym(SK, 8, BIT, 1, 3);
    endtask

    always @(negedge clk) begin
        if (eop && rx_error) begin
            errors++;
            $display("FAIL eop_and_error: eop=%0d rx_error=%0d both high", eop, rx_error);
        end
        if (bit_valid || eop || rx_error) begin
            int   k;
            exp_t e;
            k = bit_valid ? BIT : eop ? EOPK : ERR;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: kind %0d bit %0d at cycle %0d, none expected", k, bit_out, cyc);
            end else begin
                e = exp_q.pop_front();
                if (k != e.kind || (k == BIT && bit_out != e.val[0])) begin
                    errors++;
                    $display("FAIL strobe: kind %0d bit %0d, expected kind %0d bit %0d", k, bit_out, e.kind, e.val);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL strobe_time: cycle %0d, expected %0d", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {bit_out, bit_valid, eop, rx_error}, 0);
        chk("reset_receiving", receiving, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Reset mid-packet with lines at J
        sym(SK, 8, BIT, 0, 3);
        sym(SJ, 8, BIT, 0, 3);
        chk("mid_receiving", receiving, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_outputs", {bit_out, bit_valid, eop, rx_error}, 0);
        chk("midrst_receiving", receiving, 0);
        @(negedge clk);
        rst = 1'b0;
        sym(SJ, 12, NONE, 0, 0);

        // SE0 while idle is ignored
        sym(SE0, 10, NONE, 0, 0);
        sym(SJ, 10, NONE, 0, 0);
        chk("idle_se0_receiving", receiving, 0);

        // SYNC, then five held K (with SYNC's final 1 makes six 1s), stuffed 0, a 1, EOP
        sync_pat();
        chk("sync_receiving", receiving, 1);
        for (int i = 0; i < 5; i++) sym(SK, 8, BIT, 1, 3);
        sym(SJ, 8, NONE, 0, 0);
        sym(SJ, 8, BIT, 1, 3);
        chk("stuff_receiving", receiving, 1);
        sym(SE0, 8, NONE, 0, 0);
        sym(SE0, 8, NONE, 0, 0);
        chk("se0_receiving", receiving, 1);
        sym(SJ, 8, EOPK, 0, 3);
        chk("eop_receiving", receiving, 0);
        sym(SJ, 8, NONE, 0, 0);

        // Stuff violation: six held K after SYNC
        sync_pat();
        for (int i = 0; i < 5; i++) sym(SK, 8, BIT, 1, 3);
        sym(SK, 8, ERR, 0, 3);
        chk("stufferr_receiving", receiving, 0);
        sym(SJ, 16, NONE, 0, 0);

        // Jitter: 7/9-clock bits, held bits sampled from the last edge
        sym(SK, 7, BIT, 0, 3);
        sym(SJ, 9, BIT, 0, 3);
        sym(SK, 7, BIT, 0, 3);
        sym(SJ, 9, BIT, 0, 3);
        sym(SK, 7, BIT, 0, 3);
        sym(SJ, 9, BIT, 0, 3);
        sym(SK, 9, BIT, 0, 3);
        sym(SK, 8, BIT, 1, 2);
        sym(SJ, 7, BIT, 0, 3);
        sym(SJ, 8, BIT, 1, 4);
        sym(SE0, 8, NONE, 0, 0);
        sym(SE0, 8, NONE, 0, 0);
        sym(SJ, 8, EOPK, 0, 3);
        chk("jitter_eop_receiving", receiving, 0);

        // Bad EOP: SE0 followed by K
        sync_pat();
        sym(SE0, 8, NONE, 0, 0);
        sym(SK, 8, ERR, 0, 3);
        chk("bad_eop_receiving", receiving, 0);
        sym(SJ, 10, NONE, 0, 0);

        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
